// File: rtl/eleven_bit_down_timer.sv
// Loadable down-counter with IDLE/RUN/EXPIRED states and a one-cycle Done pulse on expiry.
// All outputs are registered or state-decoded; there is no flow control, and inputs are sampled every edge.
module eleven_bit_down_timer #(
   parameter int WIDTH = 11
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   input  logic             Enable,
   input  logic             Clear,
   output logic [WIDTH-1:0] Count,
   output logic             Busy,
   output logic             Done,
   output logic             Expired
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] count_next;
   logic             done_next;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         Count <= '0;
         Done  <= 1'b0;
      end else begin
         state <= state_next;
         Count <= count_next;
         Done  <= done_next;
      end
   end

   // Clear beats Load beats Enable; Done is only ever raised by an expiry this edge.
   always_comb begin
      state_next = state;
      count_next = Count;
      done_next  = 1'b0;
      if (Clear) begin
         state_next = IDLE;
         count_next = '0;
      end else if (Load) begin
         count_next = LoadValue;
         if (LoadValue == '0) begin
            state_next = EXPIRED;
            done_next  = 1'b1;
         end else begin
            state_next = RUN;
         end
      end else begin
         case (state)
            RUN: begin
               if (Enable) begin
                  // Count <= 1 rather than == 1 so a zero count can never wrap.
                  if (Count <= WIDTH'(1)) begin
                     count_next = '0;
                     state_next = EXPIRED;
                     done_next  = 1'b1;
                  end else begin
                     count_next = Count - WIDTH'(1);
                  end
               end
            end
            IDLE:    state_next = IDLE;
            EXPIRED: state_next = EXPIRED;
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   assign Busy    = (state == RUN);
   assign Expired = (state == EXPIRED);

endmodule

// File: tb/tb_eleven_bit_down_timer.sv
// Directed-vector bench: stimulus pushes expected post-edge outputs, a monitor pops and compares each cycle.
module tb_eleven_bit_down_timer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Load = 1'b0;
   logic [10:0] LoadValue = '0;
   logic        Enable = 1'b0;
   logic        Clear = 1'b0;
   logic [10:0] Count;
   logic        Busy;
   logic        Done;
   logic        Expired;

   eleven_bit_down_timer #(.WIDTH(11)) dut (
      .Clock(Clock), .Reset(Reset), .Load(Load), .LoadValue(LoadValue),
      .Enable(Enable), .Clear(Clear), .Count(Count), .Busy(Busy),
      .Done(Done), .Expired(Expired)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [10:0] c;
      logic        b;
      logic        d;
      logic        x;
      logic [15:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   vec_id = 0;

   task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s vec%0d got=%0d want=%0d at t=%0t", nm, id, got, want, $time);
      end
   endtask

   task automatic chk_all(input int id, input exp_t e);
      chk("count",   id, 32'(Count),   32'(e.c));
      chk("busy",    id, 32'(Busy),    32'(e.b));
      chk("done",    id, 32'(Done),    32'(e.d));
      chk("expired", id, 32'(Expired), 32'(e.x));
   endtask

   // Inputs change on the falling edge; the expected outputs apply after the following rising edge.
   task automatic step(input logic c, input logic l, input logic [10:0] lv, input logic e,
                       input logic [10:0] xc, input logic xb, input logic xd, input logic xx);
      exp_t v;
      @(negedge Clock);
      Clear = c; Load = l; LoadValue = lv; Enable = e;
      v.c = xc; v.b = xb; v.d = xd; v.x = xx; v.id = 16'(vec_id);
      exp_q.push_back(v);
      vec_id++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_all(int'(e.id), e);
         end
      end
   end

   initial begin : stimulus
      exp_t z;
      z = '0;
      #3;
      chk_all(-1, z);
      @(negedge Clock);
      Reset = 1'b0;
      // Enable alone after reset must not move anything.
      step(0, 0, 0, 1,   0, 0, 0, 0);
      step(0, 0, 0, 1,   0, 0, 0, 0);

      // Load 5, Enable continuous
      step(0, 1, 5, 1,   5, 1, 0, 0);
      step(0, 0, 0, 1,   4, 1, 0, 0);
      step(0, 0, 0, 1,   3, 1, 0, 0);
      step(0, 0, 0, 1,   2, 1, 0, 0);
      step(0, 0, 0, 1,   1, 1, 0, 0);
      step(0, 0, 0, 1,   0, 0, 1, 1);
      step(0, 0, 0, 1,   0, 0, 0, 1);
      step(0, 0, 0, 1,   0, 0, 0, 1);

      // Load 3, Enable 1,0,0,1,1
      step(0, 1, 3, 0,   3, 1, 0, 0);
      step(0, 0, 0, 1,   2, 1, 0, 0);
      step(0, 0, 0, 0,   2, 1, 0, 0);
      step(0, 0, 0, 0,   2, 1, 0, 0);
      step(0, 0, 0, 1,   1, 1, 0, 0);
      step(0, 0, 0, 1,   0, 0, 1, 1);
      step(0, 0, 0, 0,   0, 0, 0, 1);

      // Load zero, then back-to-back zero loads keep Done high
      step(0, 1, 0, 0,   0, 0, 1, 1);
      step(0, 0, 0, 0,   0, 0, 0, 1);
      step(0, 1, 0, 1,   0, 0, 1, 1);
      step(0, 1, 0, 0,   0, 0, 1, 1);
      step(0, 0, 0, 1,   0, 0, 0, 1);
      step(1, 0, 0, 0,   0, 0, 0, 0);
      step(0, 0, 0, 1,   0, 0, 0, 0);

      // Load on the expiring edge wins, then Clear beats Load
      step(0, 1, 2, 0,   2, 1, 0, 0);
      step(0, 0, 0, 1,   1, 1, 0, 0);
      step(0, 1, 4, 1,   4, 1, 0, 0);
      step(0, 0, 0, 1,   3, 1, 0, 0);
      step(0, 1, 9, 0,   9, 1, 0, 0);
      step(0, 0, 0, 1,   8, 1, 0, 0);
      step(1, 1, 9, 1,   0, 0, 0, 0);
      step(0, 0, 0, 1,   0, 0, 0, 0);

      // Clear during the Done cycle
      step(0, 1, 1, 0,   1, 1, 0, 0);
      step(0, 0, 0, 1,   0, 0, 1, 1);
      step(1, 0, 0, 1,   0, 0, 0, 0);

      // Full-scale countdown: 2047 enabled edges, no wrap afterwards
      step(0, 1, 11'd2047, 1,   11'd2047, 1, 0, 0);
      for (int i = 2046; i >= 1; i--) step(0, 0, 0, 1, 11'(i), 1, 0, 0);
      step(0, 0, 0, 1,   0, 0, 1, 1);
      step(0, 0, 0, 1,   0, 0, 0, 1);
      step(0, 0, 0, 1,   0, 0, 0, 1);
      step(0, 0, 0, 1,   0, 0, 0, 1);

      // Asynchronous reset mid-RUN at Count=7
      step(0, 1, 10, 0,  10, 1, 0, 0);
      step(0, 0, 0, 1,   9, 1, 0, 0);
      step(0, 0, 0, 1,   8, 1, 0, 0);
      step(0, 0, 0, 1,   7, 1, 0, 0);
      @(posedge Clock);
      #2 Reset = 1'b1;
      #1 chk_all(9000, z);
      #1 Reset = 1'b0;
      step(0, 0, 0, 1,   0, 0, 0, 0);
      step(0, 0, 0, 1,   0, 0, 0, 0);
      step(0, 0, 0, 1,   0, 0, 0, 0);

      // Asynchronous reset during the Done cycle
      step(0, 1, 1, 0,   1, 1, 0, 0);
      step(0, 0, 0, 1,   0, 0, 1, 1);
      @(posedge Clock);
      #2 Reset = 1'b1;
      #1 chk_all(9001, z);
      #1 Reset = 1'b0;
      step(0, 0, 0, 1,   0, 0, 0, 0);
      step(0, 0, 0, 1,   0, 0, 0, 0);
      step(0, 0, 0, 0,   0, 0, 0, 0);

      // Bounded drain of the scoreboard
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge Clock);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
